// File: rtl/sim_step_timer_pkg.sv
`default_nettype none
// ============================================================================
// sim_step_timer_pkg : widths shared with the ctrl_time_* step-event controllers
// Revision: 1.0
// ============================================================================
package sim_step_timer_pkg;
  localparam int EXTENDED_SINGLE = 64;
  localparam int CNT_W_DEFAULT   = 12;
  localparam int DIV_W_DEFAULT   = 16;
endpackage
`default_nettype wire

// File: rtl/sim_step_timer_step_divider.sv
`default_nettype none
// ============================================================================
// step_divider : loadable modulo counter (0..last_i) with a terminal pulse
// Revision: 1.0
// ============================================================================
module step_divider
  import sim_step_timer_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         term;

  assign term   = (cnt_q == last_i);
  assign wrap_o = en_i && !clr_i && term;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sim_step_timer.sv
`default_nettype none
// ============================================================================
// sim_step_timer : paced step counter, downstream clear and double-buffered
//                  event (time, value) for the ctrl_time_* controllers
// Revision: 1.0
// ============================================================================
module sim_step_timer
  import sim_step_timer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int DIV_W = DIV_W_DEFAULT,
  parameter int VAL_W = EXTENDED_SINGLE
) (
  input  logic             clk,
  input  logic             sta,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] step_div,
  input  logic [CNT_W-1:0] n_steps,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_time,
  input  logic [VAL_W-1:0] cfg_value,
  output logic             sim_sta,
  output logic [CNT_W-1:0] counter,
  output logic             step_stb,
  output logic             wrap,
  output logic [CNT_W-1:0] time_1,
  output logic [VAL_W-1:0] value_1,
  output logic             busy
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ARM      = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_STOPPING = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             running, arm, boundary, cnt_wrap, commit;
  logic             sim_sta_d, busy_d;
  logic             sim_sta_q, busy_q, step_stb_q, wrap_q, dirty_q;
  logic [DIV_W-1:0] div_l_q, div_cnt_unused;
  logic [CNT_W-1:0] n_l_q, wrap_last;
  logic [CNT_W-1:0] shadow_time_q, time_q;
  logic [VAL_W-1:0] shadow_value_q, value_q;

  assign running   = (state_q == S_RUN) || (state_q == S_STOPPING);
  // n_l = 0 wraps at all-ones, which the modular subtraction gives for free
  assign wrap_last = n_l_q - 1'b1;

  step_divider #(.W(DIV_W)) u_div (
    .clk    (clk),
    .rst    (sta),
    .clr_i  (!running),
    .en_i   (running),
    .last_i (div_l_q),
    .cnt_o  (div_cnt_unused),
    .wrap_o (boundary)
  );

  step_divider #(.W(CNT_W)) u_step (
    .clk    (clk),
    .rst    (sta),
    .clr_i  (!running),
    .en_i   (boundary),
    .last_i (wrap_last),
    .cnt_o  (counter),
    .wrap_o (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (sta) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = S_ARM;
      S_ARM:      state_d = S_RUN;
      S_RUN:      if (stop) state_d = S_STOPPING;
      S_STOPPING: if (boundary) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // The final step of a graceful stop stays visible for one cycle before the clear
  always_comb begin
    arm       = (state_q == S_ARM);
    sim_sta_d = (state_q == S_IDLE);
    busy_d    = (state_d != S_IDLE) || (state_q == S_STOPPING);
    commit    = arm || (boundary && dirty_q);
  end

  always_ff @(posedge clk) begin
    if (sta) begin
      sim_sta_q      <= 1'b1;
      busy_q         <= 1'b0;
      step_stb_q     <= 1'b0;
      wrap_q         <= 1'b0;
      div_l_q        <= '0;
      n_l_q          <= '0;
      shadow_time_q  <= '0;
      shadow_value_q <= '0;
      dirty_q        <= 1'b0;
      time_q         <= '0;
      value_q        <= '0;
    end else begin
      sim_sta_q  <= sim_sta_d;
      busy_q     <= busy_d;
      step_stb_q <= boundary;
      wrap_q     <= cnt_wrap;
      if (arm) begin
        div_l_q <= step_div;
        n_l_q   <= n_steps;
      end
      if (cfg_we) begin
        shadow_time_q  <= cfg_time;
        shadow_value_q <= cfg_value;
      end
      // A write racing a commit leaves the new shadow pending for the next step
      dirty_q <= cfg_we | (dirty_q & ~commit);
      if (commit) begin
        time_q  <= shadow_time_q;
        value_q <= shadow_value_q;
      end
    end
  end

  assign sim_sta  = sim_sta_q;
  assign busy     = busy_q;
  assign step_stb = step_stb_q;
  assign wrap     = wrap_q;
  assign time_1   = time_q;
  assign value_1  = value_q;

endmodule
`default_nettype wire

// File: tb/tb_sim_step_timer.sv
`default_nettype none
// ============================================================================
// tb_sim_step_timer : scoreboard bench for sim_step_timer
// Revision: 1.0
// ============================================================================
module tb_sim_step_timer;
  import sim_step_timer_pkg::*;

  localparam int CNT_W = 12;
  localparam int DIV_W = 16;
  localparam int VAL_W = 64;

  logic             clk = 1'b0;
  logic             sta = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [DIV_W-1:0] step_div = '0;
  logic [CNT_W-1:0] n_steps = '0;
  logic             cfg_we = 1'b0;
  logic [CNT_W-1:0] cfg_time = '0;
  logic [VAL_W-1:0] cfg_value = '0;
  logic             sim_sta, step_stb, wrap, busy;
  logic [CNT_W-1:0] counter, time_1;
  logic [VAL_W-1:0] value_1;

  sim_step_timer #(.CNT_W(CNT_W), .DIV_W(DIV_W), .VAL_W(VAL_W)) dut (
    .clk      (clk),
    .sta      (sta),
    .start    (start),
    .stop     (stop),
    .step_div (step_div),
    .n_steps  (n_steps),
    .cfg_we   (cfg_we),
    .cfg_time (cfg_time),
    .cfg_value(cfg_value),
    .sim_sta  (sim_sta),
    .counter  (counter),
    .step_stb (step_stb),
    .wrap     (wrap),
    .time_1   (time_1),
    .value_1  (value_1),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cnt;
    logic             wrp;
    logic [CNT_W-1:0] t;
    logic [VAL_W-1:0] v;
    int               cyc;
  } ev_t;

  ev_t              sb[$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               m_p, m_div, m_n;
  logic [CNT_W-1:0] sh_t = '0;
  logic [VAL_W-1:0] sh_v = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int bcyc(int k);
    return m_p + 1 + m_div + (k - 1) * (m_div + 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(int t);
    if (cyc > t) chk("schedule", cyc, t);
    while (cyc < t) tick();
  endtask

  task automatic push_steps(int k0, int k1, logic [CNT_W-1:0] t, logic [VAL_W-1:0] v);
    ev_t e;
    for (int k = k0; k <= k1; k++) begin
      int c;
      c     = (m_n == 0) ? (k % 4096) : (k % m_n);
      e.cnt = c[CNT_W-1:0];
      e.wrp = (c == 0);
      e.t   = t;
      e.v   = v;
      e.cyc = bcyc(k) + 1;
      sb.push_back(e);
    end
  endtask

  task automatic cfg_write(int at, logic [CNT_W-1:0] t, logic [VAL_W-1:0] v);
    if (at >= 0) wait_cyc(at);
    cfg_we    = 1'b1;
    cfg_time  = t;
    cfg_value = v;
    tick();
    cfg_we = 1'b0;
    sh_t   = t;
    sh_v   = v;
  endtask

  task automatic do_start(int div, int n, logic with_stop);
    step_div = div[DIV_W-1:0];
    n_steps  = n[CNT_W-1:0];
    start    = 1'b1;
    stop     = with_stop;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    m_p   = cyc;
    m_div = div;
    m_n   = n;
    chk("arm_sim_sta", sim_sta, 1);
    chk("arm_busy", busy, 1);
    tick();
    chk("run_sim_sta", sim_sta, 0);
    chk("arm_time_1", time_1, sh_t);
    chk("arm_value_1", value_1, sh_v);
  endtask

  // stop issued off cycles after boundary k-1, so step k is the last one
  task automatic do_stop(int k, int off);
    wait_cyc(bcyc(k - 1) + off);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_cyc(bcyc(k) + 1);
    chk("stop_last_sim_sta", sim_sta, 0);
    chk("stop_last_busy", busy, 1);
    tick();
    chk("stop_sim_sta", sim_sta, 1);
    chk("stop_counter", counter, 0);
    chk("stop_busy", busy, 0);
    tick();
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge clk);
      if (step_stb === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("step_counter", counter, e.cnt);
          chk("step_wrap", wrap, e.wrp);
          chk("step_time_1", time_1, e.t);
          chk("step_value_1", value_1, e.v);
          chk("step_cycle", cyc, e.cyc);
        end
      end else if (wrap !== 1'b0) begin
        chk("wrap_without_step", wrap, 0);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    sta = 1'b1;
    tick();
    tick();
    sta = 1'b0;
    chk("rst_sim_sta", sim_sta, 1);
    chk("rst_counter", counter, 0);
    chk("rst_step_stb", step_stb, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_time_1", time_1, 0);
    chk("rst_value_1", value_1, 0);
    chk("rst_busy", busy, 0);

    // Start at div 3 / n 5 with shadow commits, including writes on boundaries
    cfg_write(-1, 12'd3, 64'd1);
    do_start(3, 5, 1'b0);
    push_steps(1, 1, 12'd3, 64'd1);
    push_steps(2, 3, 12'd10, 64'h3FF0_0000_0000_0000);
    push_steps(4, 4, 12'd20, 64'hABC);
    push_steps(5, 5, 12'd30, 64'h123);
    push_steps(6, 6, 12'd40, 64'h456);
    cfg_write(m_p + 6, 12'd10, 64'h3FF0_0000_0000_0000);
    wait_cyc(m_p + 8);
    chk("no_early_time_1", time_1, 3);
    chk("no_early_value_1", value_1, 1);
    cfg_write(m_p + 12, 12'd20, 64'hABC);
    cfg_write(m_p + 18, 12'd30, 64'h123);
    cfg_write(m_p + 20, 12'd40, 64'h456);
    do_stop(6, 3);

    // Graceful stop two clocks after a boundary at div 7
    do_start(7, 0, 1'b0);
    push_steps(1, 3, sh_t, sh_v);
    do_stop(3, 2);

    // Maximum rate, full 4096 range
    do_start(0, 0, 1'b0);
    push_steps(1, 4097, sh_t, sh_v);
    do_stop(4097, 0);

    // start+stop together in IDLE starts; start during RUN is ignored
    do_start(1, 3, 1'b1);
    push_steps(1, 5, sh_t, sh_v);
    wait_cyc(m_p + 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    do_stop(5, 1);

    // Reset pulse mid-run aborts at once
    do_start(0, 0, 1'b0);
    push_steps(1, 4, sh_t, sh_v);
    wait_cyc(m_p + 5);
    sta = 1'b1;
    tick();
    sta = 1'b0;
    sh_t = '0;
    sh_v = '0;
    chk("abort_sim_sta", sim_sta, 1);
    chk("abort_counter", counter, 0);
    chk("abort_step_stb", step_stb, 0);
    chk("abort_wrap", wrap, 0);
    chk("abort_time_1", time_1, 0);
    chk("abort_value_1", value_1, 0);
    chk("abort_busy", busy, 0);
    tick();
    chk("abort_sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
